// File: rtl/paddle_input_decoder.sv
// Paddle input decoder: synchronises and debounces a quadrature encoder and a
// fire button, decodes detents into a saturating signed pixel delta that is
// handed over once per frame strobe, and pulses FIRE on each button press.
module paddle_input_decoder #(
  parameter logic [15:0] DEBOUNCE_CYCLES   = 16'd4000,
  parameter int unsigned DELTA_WIDTH       = 6,
  parameter logic [5:0]  PIXELS_PER_DETENT = 6'd2
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          ENC_A,
  input  logic                          ENC_B,
  input  logic                          BTN_FIRE,
  input  logic                          FRAME_STROBE,
  output logic signed [DELTA_WIDTH-1:0] DELTA,
  output logic                          DELTA_VALID,
  output logic                          FIRE,
  output logic [7:0]                    ILLEGAL_COUNT
);

  localparam int unsigned NIN     = 3;
  localparam int unsigned IDX_A   = 0;
  localparam int unsigned IDX_B   = 1;
  localparam int unsigned IDX_BTN = 2;

  // Internal arithmetic width: wide enough for ACC plus a full detent step.
  localparam int unsigned SW    = DELTA_WIDTH + 8;
  localparam int unsigned MAX_I = (1 << (DELTA_WIDTH - 1)) - 1;

  localparam logic signed [SW-1:0] MAX_V = SW'(MAX_I);
  localparam logic signed [SW-1:0] MIN_V = -MAX_V;
  localparam logic signed [SW-1:0] PPD   = SW'(PIXELS_PER_DETENT);

  localparam logic [15:0] DB_LAST     = DEBOUNCE_CYCLES - 16'd1;
  localparam logic [16:0] PRIME_LIMIT = 17'(DEBOUNCE_CYCLES) + 17'd2;

  logic [NIN-1:0] raw;
  logic [NIN-1:0] sync1;
  logic [NIN-1:0] sync2;
  logic [NIN-1:0] stable;
  logic [NIN-1:0] stable_nxt;
  logic [15:0]    db_cnt     [NIN];
  logic [15:0]    db_cnt_nxt [NIN];

  logic [16:0]    prime_cnt;
  logic           primed;

  logic [1:0]     prev_ab;
  logic [1:0]     cur_ab;
  logic [1:0]     prev_ab_nxt;
  logic [1:0]     pos_cur;
  logic [1:0]     pos_prev;
  logic [1:0]     dpos;
  logic signed [3:0] qstep;
  logic           illegal;

  logic signed [2:0]    sub;
  logic signed [2:0]    sub_nxt;
  logic signed [3:0]    sub_sum;
  logic signed [SW-1:0] step;

  logic signed [DELTA_WIDTH-1:0] acc;
  logic signed [DELTA_WIDTH-1:0] acc_sat;
  logic signed [SW-1:0]          acc_ext;
  logic signed [SW-1:0]          sum;
  logic signed [SW-1:0]          clamped;

  assign raw = {BTN_FIRE, ENC_B, ENC_A};

  // Two-flop synchronisers for the asynchronous pins.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Debounce next-state: a change is accepted after DEBOUNCE_CYCLES disagreeing cycles.
  always_comb begin
    stable_nxt = stable;
    for (int unsigned i = 0; i < NIN; i++) begin
      db_cnt_nxt[i] = '0;
      if (sync2[i] != stable[i]) begin
        if (db_cnt[i] == DB_LAST) begin
          stable_nxt[i] = ~stable[i];
        end else begin
          db_cnt_nxt[i] = db_cnt[i] + 16'd1;
        end
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      stable <= '0;
      for (int unsigned i = 0; i < NIN; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      stable <= stable_nxt;
      db_cnt <= db_cnt_nxt;
    end
  end

  assign primed = (prime_cnt == PRIME_LIMIT);

  // Startup window covering synchroniser and debounce latency before decoding.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      prime_cnt <= '0;
    end else if (!primed) begin
      prime_cnt <= prime_cnt + 17'd1;
    end
  end

  // Quadrature decode: map Gray position to a 0..3 ring and take the difference.
  always_comb begin
    cur_ab   = {stable[IDX_A], stable[IDX_B]};
    pos_cur  = {cur_ab[1], cur_ab[1] ^ cur_ab[0]};
    pos_prev = {prev_ab[1], prev_ab[1] ^ prev_ab[0]};
    dpos     = pos_cur - pos_prev;
    qstep    = 4'sd0;
    illegal  = 1'b0;
    if (primed) begin
      case (dpos)
        2'd1:    qstep = 4'sd1;
        2'd3:    qstep = -4'sd1;
        2'd2:    illegal = 1'b1;
        default: qstep = 4'sd0;
      endcase
    end
    // While priming, PREV follows the value the debouncer is about to hold so
    // the first primed cycle never sees a stale resting position as a move.
    prev_ab_nxt = primed ? cur_ab : {stable_nxt[IDX_A], stable_nxt[IDX_B]};
  end

  // Detent accumulation and saturating pixel sum.
  always_comb begin
    sub_sum = $signed({sub[2], sub}) + qstep;
    sub_nxt = sub_sum[2:0];
    step    = '0;
    if (sub_sum == 4'sd4) begin
      step    = PPD;
      sub_nxt = '0;
    end else if (sub_sum == -4'sd4) begin
      step    = -PPD;
      sub_nxt = '0;
    end
    acc_ext = {{(SW - DELTA_WIDTH){acc[DELTA_WIDTH-1]}}, acc};
    sum     = acc_ext + step;
    if (sum > MAX_V) begin
      clamped = MAX_V;
    end else if (sum < MIN_V) begin
      clamped = MIN_V;
    end else begin
      clamped = sum;
    end
    acc_sat = clamped[DELTA_WIDTH-1:0];
  end

  // Decode state, accumulator, frame hand-over and registered outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      prev_ab       <= '0;
      sub           <= '0;
      acc           <= '0;
      DELTA         <= '0;
      DELTA_VALID   <= 1'b0;
      FIRE          <= 1'b0;
      ILLEGAL_COUNT <= '0;
    end else begin
      prev_ab     <= prev_ab_nxt;
      sub         <= sub_nxt;
      DELTA_VALID <= FRAME_STROBE;
      if (FRAME_STROBE) begin
        DELTA <= acc_sat;
        acc   <= '0;
      end else begin
        acc <= acc_sat;
      end
      if (illegal && (ILLEGAL_COUNT != 8'hFF)) begin
        ILLEGAL_COUNT <= ILLEGAL_COUNT + 8'd1;
      end
      FIRE <= stable_nxt[IDX_BTN] & ~stable[IDX_BTN];
    end
  end

endmodule
